kfps2kb_host_tx: RTL and testbench

PS/2 host-to-device transmitter: sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), from the core to the attached keyboard. It uses the standard request-to-send sequence, odd parity and device acknowledge. It shares the open-drain `device_clock`/`device_data` lines with the keyboard receiver and raises `tx_active` so the receiver ignores line activity while a transmission is in progress.

---
 rtl/kfps2kb_host_tx_if.sv | 14 +
 rtl/kfps2kb_host_tx.sv | 183 ++++++++++++++++++
 tb/tb_kfps2kb_host_tx.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/kfps2kb_host_tx_if.sv
// Core-side command handshake of the PS/2 host transmitter.
interface kfps2kb_host_tx_if;
  logic       send_request;
  logic [7:0] send_data;
  logic       busy;
  logic       tx_active;
  logic       send_done;
  logic       send_error;

  modport master (output send_request, send_data,
                  input  busy, tx_active, send_done, send_error);
  modport slave  (input  send_request, send_data,
                  output busy, tx_active, send_done, send_error);
endinterface

// File: rtl/kfps2kb_host_tx.sv
// PS/2 host-to-device command transmitter (request-to-send, odd parity, device ACK).
// Optional KFPS2KB_TX_ACK_CHECK_EN: a missing ACK ends the transfer with send_error.
module kfps2kb_host_tx #(
  parameter logic [15:0] INHIBIT_CYCLES = 16'd2000,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd300000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic device_clock,
  input  logic device_data,
  output logic device_clock_oe,
  output logic device_data_oe,
  kfps2kb_host_tx_if.slave host
);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK, RELEASE
  } state_t;

  state_t      state, state_nxt;
  logic        clk_meta, clk_sync, clk_prev, dat_meta, dat_sync;
  logic [7:0]  byte_q, byte_nxt;
  logic        parity_q, parity_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic [15:0] inh_cnt, inh_cnt_nxt;
  logic [19:0] to_cnt, to_cnt_nxt;
  logic        clock_oe_nxt, data_oe_nxt, busy_nxt, done_nxt, err_nxt;
  logic        fall, counting, timeout;
`ifdef KFPS2KB_TX_ACK_CHECK_EN
  logic        ack_bad, ack_bad_nxt;
`endif

  // Line synchronizers; idle-high reset so no edge is seen coming out of reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= device_clock;
      clk_sync <= clk_meta;
      clk_prev <= clk_sync;
      dat_meta <= device_data;
      dat_sync <= dat_meta;
    end
  end

  assign fall     = clk_prev & ~clk_sync;
  assign counting = (state != IDLE) && (state != INHIBIT);
  assign timeout  = counting && (to_cnt == TIMEOUT_CYCLES - 20'd1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      byte_q          <= 8'd0;
      parity_q        <= 1'b0;
      bit_idx         <= 3'd0;
      inh_cnt         <= 16'd0;
      to_cnt          <= 20'd0;
      device_clock_oe <= 1'b0;
      device_data_oe  <= 1'b0;
      host.busy       <= 1'b0;
      host.tx_active  <= 1'b0;
      host.send_done  <= 1'b0;
      host.send_error <= 1'b0;
`ifdef KFPS2KB_TX_ACK_CHECK_EN
      ack_bad         <= 1'b0;
`endif
    end else begin
      state           <= state_nxt;
      byte_q          <= byte_nxt;
      parity_q        <= parity_nxt;
      bit_idx         <= bit_idx_nxt;
      inh_cnt         <= inh_cnt_nxt;
      to_cnt          <= to_cnt_nxt;
      device_clock_oe <= clock_oe_nxt;
      device_data_oe  <= data_oe_nxt;
      host.busy       <= busy_nxt;
      host.tx_active  <= busy_nxt;
      host.send_done  <= done_nxt;
      host.send_error <= err_nxt;
`ifdef KFPS2KB_TX_ACK_CHECK_EN
      ack_bad         <= ack_bad_nxt;
`endif
    end
  end

  // Next state and next registered line drive; data_oe holds between edges
  always_comb begin
    state_nxt    = state;
    byte_nxt     = byte_q;
    parity_nxt   = parity_q;
    bit_idx_nxt  = bit_idx;
    inh_cnt_nxt  = inh_cnt;
    to_cnt_nxt   = counting ? to_cnt + 20'd1 : to_cnt;
    clock_oe_nxt = 1'b0;
    data_oe_nxt  = device_data_oe;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
`ifdef KFPS2KB_TX_ACK_CHECK_EN
    ack_bad_nxt  = ack_bad;
`endif
    if (fall) to_cnt_nxt = 20'd0;

    case (state)
      IDLE: begin
        data_oe_nxt = 1'b0;
        if (host.send_request) begin
          byte_nxt     = host.send_data;
          parity_nxt   = ~^host.send_data;
          bit_idx_nxt  = 3'd0;
          inh_cnt_nxt  = 16'd0;
          to_cnt_nxt   = 20'd0;
          clock_oe_nxt = 1'b1;
          data_oe_nxt  = (INHIBIT_CYCLES == 16'd1);
          state_nxt    = INHIBIT;
`ifdef KFPS2KB_TX_ACK_CHECK_EN
          ack_bad_nxt  = 1'b0;
`endif
        end
      end
      INHIBIT: begin
        clock_oe_nxt = 1'b1;
        if (inh_cnt == INHIBIT_CYCLES - 16'd1) begin
          clock_oe_nxt = 1'b0;
          data_oe_nxt  = 1'b1;
          to_cnt_nxt   = 20'd0;
          state_nxt    = START;
        end else begin
          inh_cnt_nxt = inh_cnt + 16'd1;
          data_oe_nxt = (inh_cnt + 16'd1 == INHIBIT_CYCLES - 16'd1);
        end
      end
      START: if (fall) begin
        bit_idx_nxt = 3'd0;
        data_oe_nxt = ~byte_q[0];
        state_nxt   = DATA;
      end
      DATA: if (fall) begin
        bit_idx_nxt = bit_idx + 3'd1;
        data_oe_nxt = ~byte_q[3'(bit_idx + 3'd1)];
        if (bit_idx == 3'd6) state_nxt = PARITY;
      end
      PARITY: if (fall) begin
        data_oe_nxt = ~parity_q;
        state_nxt   = STOP;
      end
      STOP: if (fall) begin
        data_oe_nxt = 1'b0;
        state_nxt   = ACK;
      end
      ACK: if (fall) begin
`ifdef KFPS2KB_TX_ACK_CHECK_EN
        ack_bad_nxt = dat_sync;
`endif
        state_nxt = RELEASE;
      end
      RELEASE: if (clk_sync && dat_sync) begin
        state_nxt = IDLE;
`ifdef KFPS2KB_TX_ACK_CHECK_EN
        done_nxt  = ~ack_bad;
        err_nxt   = ack_bad;
`else
        done_nxt  = 1'b1;
`endif
      end
      default: state_nxt = IDLE;
    endcase

    // A stalled device wins over any edge seen in the same cycle
    if (timeout) begin
      state_nxt    = IDLE;
      clock_oe_nxt = 1'b0;
      data_oe_nxt  = 1'b0;
      done_nxt     = 1'b0;
      err_nxt      = 1'b1;
    end
    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_kfps2kb_host_tx.sv
// Self-checking bench for kfps2kb_host_tx with an open-drain PS/2 device model.
module tb_kfps2kb_host_tx;
  localparam int unsigned CYC_LOW  = 20;
  localparam int unsigned CYC_HIGH = 20;
`ifdef KFPS2KB_TX_ACK_CHECK_EN
  localparam bit ACK_ERR = 1'b1;
`else
  localparam bit ACK_ERR = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic device_clock, device_data, device_clock_oe, device_data_oe;
  int   errors = 0, checks = 0;
  int   done_cnt = 0, err_cnt = 0, both_cnt = 0;

  kfps2kb_host_tx_if hif();

  kfps2kb_host_tx #(.INHIBIT_CYCLES(16'd8), .TIMEOUT_CYCLES(20'd64)) dut (
    .clock(clock), .reset_n(reset_n),
    .device_clock(device_clock), .device_data(device_data),
    .device_clock_oe(device_clock_oe), .device_data_oe(device_data_oe),
    .host(hif.slave)
  );

  assign device_clock = dev_clk & ~device_clock_oe;
  assign device_data  = dev_dat & ~device_data_oe;

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (hif.send_done) done_cnt++;
    if (hif.send_error) err_cnt++;
    if (hif.send_done && hif.send_error) both_cnt++;
  end

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic       exp_par;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic odd_parity(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (device_clock && !device_data) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One device clock pulse; samples the data line late in the low phase
  task automatic pulse(input bit drive_ack, input logic ack, output logic smp);
    if (drive_ack) dev_dat = ack;
    dev_clk = 1'b0;
    repeat (CYC_LOW - 5) @(negedge clock);
    smp = device_data;
    repeat (5) @(negedge clock);
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    repeat (CYC_HIGH) @(negedge clock);
  endtask

  task automatic device_xfer(input logic ack, output logic [9:0] vals);
    bit ok;
    logic smp;
    vals = '0;
    wait_start(ok);
    check("start_seen", 32'(ok), 32'd1);
    if (!ok) return;
    repeat (10) @(negedge clock);
    for (int k = 0; k < 11; k++) begin
      pulse(k == 10, ack, smp);
      if (k < 10) vals[k] = smp;
    end
  endtask

  task automatic run_xfer(input logic [7:0] d, input logic ack, input bit extra,
                          output logic [7:0] got, output logic par, output logic stp,
                          output int dd, output int de);
    int d0, e0;
    logic [9:0] vals;
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clock);
    hif.send_request = 1'b1;
    hif.send_data = d;
    @(negedge clock);
    hif.send_request = 1'b0;
    hif.send_data = ~d;
    fork
      device_xfer(ack, vals);
      begin
        if (extra) begin
          repeat (100) @(negedge clock);
          hif.send_request = 1'b1;
          hif.send_data = 8'hF4;
          @(negedge clock);
          hif.send_request = 1'b0;
        end
      end
    join
    repeat (30) @(negedge clock);
    got = vals[7:0];
    par = vals[8];
    stp = vals[9];
    dd = done_cnt - d0;
    de = err_cnt - e0;
  endtask

  task automatic xfer_and_check(input string tag, input logic [7:0] d, input logic ack,
                                input bit extra, input logic ep, input logic edn,
                                input logic eer);
    logic [7:0] got;
    logic par, stp;
    int dd, de;
    run_xfer(d, ack, extra, got, par, stp, dd, de);
    check({tag, "_byte"}, 32'(got), 32'(d));
    check({tag, "_parity"}, 32'(par), 32'(ep));
    check({tag, "_stop"}, 32'(stp), 32'd1);
    check({tag, "_done"}, 32'(dd), 32'(edn));
    check({tag, "_error"}, 32'(de), 32'(eer));
    check({tag, "_busy_after"}, 32'(hif.busy), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int first_err, e0, d0;
    logic smp;
    bit ok;
    logic [7:0] rd;
    logic ra;

    hif.send_request = 1'b0;
    hif.send_data = 8'h00;
    vecs[0] = '{8'hED, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h01, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h07, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'hAA, 1'b1, 1'b1, ~ACK_ERR, ACK_ERR};

    #1;
    check("rst_outputs", {26'd0, device_clock_oe, device_data_oe, hif.busy, hif.tx_active,
                          hif.send_done, hif.send_error}, 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    // Accept latency, inhibit window and timeout with a silent device
    @(negedge clock);
    hif.send_request = 1'b1;
    hif.send_data = 8'h55;
    first_err = 0;
    dev_clk = 1'b1;
    for (int c = 1; c < 200; c++) begin
      @(negedge clock);
      hif.send_request = 1'b0;
      if (c == 1) begin
        check("acc_busy", 32'(hif.busy), 32'd1);
        check("acc_tx_active", 32'(hif.tx_active), 32'd1);
        check("acc_clock_oe", 32'(device_clock_oe), 32'd1);
      end
      if (c == 7) check("inh_data_oe_early", 32'(device_data_oe), 32'd0);
      if (c == 8) check("inh_last", {30'd0, device_clock_oe, device_data_oe}, 32'd3);
      if (c == 9) check("start_drive", {30'd0, device_clock_oe, device_data_oe}, 32'd1);
      if (hif.send_error) begin
        first_err = c;
        check("to_lines", {29'd0, device_clock_oe, device_data_oe, hif.busy}, 32'd0);
        break;
      end
    end
    check("to_latency", 32'(first_err), 32'd73);
    repeat (5) @(negedge clock);

    for (int i = 0; i < 6; i++)
      xfer_and_check($sformatf("vec%0d", i), vecs[i].data, vecs[i].ack, 1'b0,
                     vecs[i].exp_par, vecs[i].exp_done, vecs[i].exp_err);

    for (int i = 0; i < 5; i++) begin
      rd = 8'($urandom_range(255));
      ra = 1'($urandom_range(1));
      xfer_and_check($sformatf("rnd%0d", i), rd, ra, 1'b0, odd_parity(rd),
                     ~(ra & ACK_ERR), ra & ACK_ERR);
    end

    xfer_and_check("ignore_req", 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("ignore_idle", 32'(hif.busy), 32'd0);

    // Asynchronous reset after the fifth device clock edge
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clock);
    hif.send_request = 1'b1;
    hif.send_data = 8'h00;
    @(negedge clock);
    hif.send_request = 1'b0;
    wait_start(ok);
    check("rst_start_seen", 32'(ok), 32'd1);
    repeat (10) @(negedge clock);
    for (int k = 0; k < 4; k++) pulse(1'b0, 1'b0, smp);
    dev_clk = 1'b0;
    repeat (10) @(negedge clock);
    check("rst_pre_data_oe", 32'(device_data_oe), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_lines", {29'd0, device_clock_oe, device_data_oe, hif.busy}, 32'd0);
    dev_clk = 1'b1;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    check("rst_no_pulse", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);
    check("rst_idle", {30'd0, hif.busy, device_clock_oe}, 32'd0);
    xfer_and_check("post_rst", 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    check("never_both", 32'(both_cnt), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench time limit");
  end
endmodule
